// File: rtl/cla_sub_serial.sv
// Purpose : iterative unsigned subtractor d = a - b - bin, one 4-bit lookahead slice per clock, LS nibble first.
// Latency : out_valid rises WIDTH/4 clocks after the accepting edge; repeat interval WIDTH/4+2 with out_ready high.
// Backpr. : result held in DONE until out_ready; in_ready low while busy, so no operands are taken mid-operation.
//
// Ports: clk/rst (async active-high); in_valid/in_ready with a, b, bin; out_valid/out_ready with d, bout;
//        busy is high in CALC or DONE. Optional macro CLA_SUB_OVF_EN adds ovf (signed overflow of a - b - bin).
module cla_sub_serial #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] d,
  output logic             bout,
  output logic             busy
`ifdef CLA_SUB_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int NIB = WIDTH / 4;
  localparam int KW  = (NIB > 1) ? $clog2(NIB) : 1;

  generate
    if ((WIDTH % 4) != 0 || WIDTH < 4) begin : g_bad_width
      $error("cla_sub_serial: WIDTH must be a multiple of 4 and at least 4");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t            state, state_nxt;
  logic [WIDTH-1:0]  a_q, b_q, d_q;
  logic [KW-1:0]     k_q;
  logic              brw_q;
  logic              bout_q;
  logic              last;

  // Lookahead slice: a + ~b + ~borrow on the current nibble.
  logic [3:0] an, bn, p, g, sum;
  logic       c0, c1, c2, c3, c4;

  always_comb begin
    an = a_q[{k_q, 2'b00} +: 4];
    bn = ~b_q[{k_q, 2'b00} +: 4];
    p  = an ^ bn;
    g  = an & bn;
    c0 = ~brw_q;
    c1 = g[0] | (p[0] & c0);
    c2 = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c0);
    c3 = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c0);
    c4 = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
       | (p[3] & p[2] & p[1] & p[0] & c0);
    sum = p ^ {c3, c2, c1, c0};
  end

  assign last = (k_q == KW'(NIB - 1));

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_valid)  state_nxt = CALC;
      CALC:    if (last)      state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default:                state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q    <= '0;
      b_q    <= '0;
      d_q    <= '0;
      k_q    <= '0;
      brw_q  <= 1'b0;
      bout_q <= 1'b0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          a_q   <= a;
          b_q   <= b;
          brw_q <= bin;
          k_q   <= '0;
        end
        CALC: begin
          d_q[{k_q, 2'b00} +: 4] <= sum;
          brw_q                  <= ~c4;
          k_q                    <= k_q + KW'(1);
          if (last) bout_q <= ~c4;
        end
        default: ;
      endcase
    end
  end

`ifdef CLA_SUB_OVF_EN
  // sum[3] on the final slice is the result sign bit.
  logic ovf_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) ovf_q <= 1'b0;
    else if (state == CALC && last)
      ovf_q <= (a_q[WIDTH-1] != b_q[WIDTH-1]) && (sum[3] != a_q[WIDTH-1]);
  end
  assign ovf = ovf_q;
`endif

  // Handshake outputs decode straight from state so reset clears them with no clock.
  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);
  assign d         = d_q;
  assign bout      = bout_q;

endmodule

// File: tb/tb_cla_sub_serial.sv
module tb_cla_sub_serial;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] a = '0;
  logic [15:0] b = '0;
  logic        bin = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [15:0] d;
  logic        bout;
  logic        busy;
`ifdef CLA_SUB_OVF_EN
  logic        ovf;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  cla_sub_serial #(.WIDTH(16)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .bin(bin),
    .out_valid(out_valid), .out_ready(out_ready),
    .d(d), .bout(bout), .busy(busy)
`ifdef CLA_SUB_OVF_EN
    , .ovf(ovf)
`endif
  );

  always #5 clk = ~clk;

  // Present one operand set for one edge, then count edges until out_valid (bounded).
  task automatic do_op(input logic [15:0] av, input logic [15:0] bv, input logic bv_in, output int lat);
    @(negedge clk);
    in_valid = 1'b1; a = av; b = bv; bin = bv_in;
    @(negedge clk);
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic test_reset;
    #2;
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    n_checks++; if (d !== 16'h0000) begin n_fail++; $display("FAIL reset_d got %h want 0000", d); end
    n_checks++; if (bout !== 1'b0) begin n_fail++; $display("FAIL reset_bout got %b want 0", bout); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", busy); end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_basic;
    int lat;
    do_op(16'h1234, 16'h0034, 1'b0, lat);
    n_checks++; if (lat !== 4) begin n_fail++; $display("FAIL basic_latency got %0d want 4", lat); end
    n_checks++; if (d !== 16'h1200) begin n_fail++; $display("FAIL basic_d got %h want 1200", d); end
    n_checks++; if (bout !== 1'b0) begin n_fail++; $display("FAIL basic_bout got %b want 0", bout); end
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL basic_busy got %b want 1", busy); end
`ifdef CLA_SUB_OVF_EN
    n_checks++; if (ovf !== 1'b0) begin n_fail++; $display("FAIL basic_ovf got %b want 0", ovf); end
`endif
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    n_checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_fail++; $display("FAIL basic_release got ov=%b ir=%b want ov=0 ir=1", out_valid, in_ready);
    end
  endtask

  task automatic test_underflow;
    int lat;
    do_op(16'h0000, 16'h0001, 1'b0, lat);
    n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL uf_valid got %b want 1 (waited %0d)", out_valid, lat); end
    n_checks++; if (d !== 16'hFFFF) begin n_fail++; $display("FAIL uf_d got %h want ffff", d); end
    n_checks++; if (bout !== 1'b1) begin n_fail++; $display("FAIL uf_bout got %b want 1", bout); end
    out_ready = 1'b1; @(negedge clk); out_ready = 1'b0;
  endtask

  task automatic test_equal_bin;
    int lat;
    do_op(16'h0005, 16'h0005, 1'b1, lat);
    n_checks++; if (d !== 16'hFFFF) begin n_fail++; $display("FAIL eq_bin1_d got %h want ffff", d); end
    n_checks++; if (bout !== 1'b1) begin n_fail++; $display("FAIL eq_bin1_bout got %b want 1", bout); end
    out_ready = 1'b1; @(negedge clk); out_ready = 1'b0;
    do_op(16'h0005, 16'h0005, 1'b0, lat);
    n_checks++; if (d !== 16'h0000) begin n_fail++; $display("FAIL eq_bin0_d got %h want 0000", d); end
    n_checks++; if (bout !== 1'b0) begin n_fail++; $display("FAIL eq_bin0_bout got %b want 0", bout); end
    out_ready = 1'b1; @(negedge clk); out_ready = 1'b0;
  endtask

`ifdef CLA_SUB_OVF_EN
  task automatic test_ovf;
    int lat;
    do_op(16'h8000, 16'h0001, 1'b0, lat);
    n_checks++; if (d !== 16'h7FFF) begin n_fail++; $display("FAIL ovf1_d got %h want 7fff", d); end
    n_checks++; if (ovf !== 1'b1) begin n_fail++; $display("FAIL ovf1_ovf got %b want 1", ovf); end
    n_checks++; if (bout !== 1'b0) begin n_fail++; $display("FAIL ovf1_bout got %b want 0", bout); end
    out_ready = 1'b1; @(negedge clk); out_ready = 1'b0;
    do_op(16'h7FFF, 16'hFFFF, 1'b0, lat);
    n_checks++; if (d !== 16'h8000) begin n_fail++; $display("FAIL ovf2_d got %h want 8000", d); end
    n_checks++; if (ovf !== 1'b1) begin n_fail++; $display("FAIL ovf2_ovf got %b want 1", ovf); end
    n_checks++; if (bout !== 1'b1) begin n_fail++; $display("FAIL ovf2_bout got %b want 1", bout); end
    out_ready = 1'b1; @(negedge clk); out_ready = 1'b0;
  endtask
`endif

  task automatic test_backpressure;
    int lat;
    do_op(16'hA5A5, 16'h5A5A, 1'b1, lat);
    n_checks++; if (d !== 16'h4B4A) begin n_fail++; $display("FAIL bp_d got %h want 4b4a", d); end
    n_checks++; if (bout !== 1'b0) begin n_fail++; $display("FAIL bp_bout got %b want 0", bout); end
    in_valid = 1'b1; a = 16'h0003; b = 16'h0001; bin = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      n_checks++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || d !== 16'h4B4A || bout !== 1'b0) begin
        n_fail++;
        $display("FAIL bp_hold cycle %0d got ov=%b ir=%b d=%h bout=%b want ov=1 ir=0 d=4b4a bout=0",
                 i, out_valid, in_ready, d, bout);
      end
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    n_checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin
      n_fail++; $display("FAIL bp_release got ov=%b ir=%b busy=%b want 0 1 0", out_valid, in_ready, busy);
    end
    do_op(16'h0003, 16'h0001, 1'b0, lat);
    n_checks++; if (d !== 16'h0002) begin n_fail++; $display("FAIL bp_next_d got %h want 0002", d); end
    n_checks++; if (bout !== 1'b0) begin n_fail++; $display("FAIL bp_next_bout got %b want 0", bout); end
    out_ready = 1'b1; @(negedge clk); out_ready = 1'b0;
  endtask

  task automatic test_reset_mid;
    int lat;
    @(negedge clk);
    in_valid = 1'b1; a = 16'h1111; b = 16'h0000; bin = 1'b0;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL rm_busy_before got %b want 1", busy); end
    #2 rst = 1'b1;
    #1;
    n_checks++;
    if (out_valid !== 1'b0 || d !== 16'h0000 || bout !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL rm_async got ov=%b d=%h bout=%b busy=%b want 0 0000 0 0", out_valid, d, bout, busy);
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    n_checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      n_fail++; $display("FAIL rm_after got ir=%b ov=%b want 1 0", in_ready, out_valid);
    end
    do_op(16'hFFFF, 16'h0001, 1'b0, lat);
    n_checks++; if (d !== 16'hFFFE) begin n_fail++; $display("FAIL rm_next_d got %h want fffe", d); end
    n_checks++; if (bout !== 1'b0) begin n_fail++; $display("FAIL rm_next_bout got %b want 0", bout); end
    out_ready = 1'b1; @(negedge clk); out_ready = 1'b0;
  endtask

  initial begin
    test_reset;
    test_basic;
    test_underflow;
    test_equal_bin;
`ifdef CLA_SUB_OVF_EN
    test_ovf;
`endif
    test_backpressure;
    test_reset_mid;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
